// File: rtl/regs_sb.sv
// rtl/regs_sb.sv - register file with writeback bypass and per-register pending-write scoreboard
//
// Purpose: 31 x 32-bit architectural registers (x0 hardwired to zero), two
// combinational read ports with same-cycle writeback bypass, and a 2-bit
// pending-write counter per register that raises hazard_o to stall issue.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rs1_addr_i/rs2_addr_i read indices from decode
//   rs1_data_o/rs2_data_o read data back to decode (0-cycle latency)
//   issue_valid_i        decode presents an instruction this cycle
//   issue_wen_i          issuing instruction writes rd
//   issue_rd_i           destination of the issuing instruction
//   wb_wen_i/wb_rd_i/wb_data_i  writeback strobe, destination, data
//   hazard_o             stall request; issue is refused while high

module regs_sb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        issue_valid_i,
  input  logic        issue_wen_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        wb_wen_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        hazard_o
);

  // Entry 0 of both arrays is only ever cleared, so x0 reads 0 and never pends.
  logic [31:0] regs_q [32];
  logic [1:0]  cnt_q  [32];
  logic [1:0]  cnt_d  [32];

  logic issue_fire;
  logic inc;
  logic dec;
  logic rs1_busy;
  logic rs2_busy;
  logic rs1_haz;
  logic rs2_haz;
  logic full_haz;

  assign dec        = wb_wen_i & (wb_rd_i != 5'd0);
  assign issue_fire = issue_valid_i & ~hazard_o;
  assign inc        = issue_fire & issue_wen_i & (issue_rd_i != 5'd0);

  // Effective pending count: a writeback retiring this cycle already
  // satisfies one outstanding write, and its data reaches the operand
  // through the bypass.
  always_comb begin
    rs1_busy = (cnt_q[rs1_addr_i] != 2'd0);
    if (dec && (wb_rd_i == rs1_addr_i)) begin
      rs1_busy = (cnt_q[rs1_addr_i] > 2'd1);
    end
    rs2_busy = (cnt_q[rs2_addr_i] != 2'd0);
    if (dec && (wb_rd_i == rs2_addr_i)) begin
      rs2_busy = (cnt_q[rs2_addr_i] > 2'd1);
    end
  end

  assign rs1_haz  = (rs1_addr_i != 5'd0) & rs1_busy;
  assign rs2_haz  = (rs2_addr_i != 5'd0) & rs2_busy;
  // Full test uses the raw count: a retiring writeback does not free a slot
  // for an issue in the same cycle.
  assign full_haz = issue_wen_i & (issue_rd_i != 5'd0) & (cnt_q[issue_rd_i] == 2'd3);
  assign hazard_o = issue_valid_i & (rs1_haz | rs2_haz | full_haz);

  always_comb begin
    rs1_data_o = '0;
    if (rs1_addr_i != 5'd0) begin
      rs1_data_o = (dec && (wb_rd_i == rs1_addr_i)) ? wb_data_i : regs_q[rs1_addr_i];
    end
    rs2_data_o = '0;
    if (rs2_addr_i != 5'd0) begin
      rs2_data_o = (dec && (wb_rd_i == rs2_addr_i)) ? wb_data_i : regs_q[rs2_addr_i];
    end
  end

  always_comb begin
    cnt_d[0] = 2'd0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc && (issue_rd_i == 5'(i)) && !(dec && (wb_rd_i == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec && (wb_rd_i == 5'(i)) && !(inc && (issue_rd_i == 5'(i)))
                   && (cnt_q[i] != 2'd0)) begin
        // A writeback with nothing pending is a protocol error: the data is
        // still written below but the counter stays at 0.
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= 2'd0;
      end
    end else begin
      if (dec) begin
        regs_q[wb_rd_i] <= wb_data_i;
      end
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
